// File: rtl/clkperiod_meter.sv
// -----------------------------------------------------------------------------
// clkperiod_meter
//
// Measures a slow, asynchronous clock (for example the output of a counter
// based divider) in cycles of the fast clock i_clk. For every full period of
// i_sig it reports the period length and the number of cycles i_sig was high.
// It also compares the period against i_expect within +/- TOL and raises a
// timeout flag when no rising edge arrives for MAX_PERIOD cycles.
//
// Ports
//   i_clk      in   1      sole clock, rising edge
//   i_rst_n    in   1      synchronous, active-low reset
//   i_sig      in   1      measured clock, asynchronous to i_clk
//   i_expect   in   WIDTH  expected period in cycles, sampled when a result is stored
//   o_period   out  WIDTH  last measured period in cycles
//   o_high     out  WIDTH  cycles i_sig was high within that period
//   o_valid    out  1      one-cycle pulse, o_period/o_high/o_match updated
//   o_match    out  1      |o_period - i_expect| <= TOL for the last result
//   o_timeout  out  1      level, no rising edge for MAX_PERIOD cycles
// -----------------------------------------------------------------------------
module clkperiod_meter #(
    parameter int unsigned      WIDTH      = 25,
    parameter logic [WIDTH-1:0] MAX_PERIOD = 25'd30000000,
    parameter logic [WIDTH-1:0] TOL        = 25'd2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sig,
    input  logic [WIDTH-1:0] i_expect,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_valid,
    output logic             o_match,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no edge seen yet
        ST_MEAS = 2'd1,   // counting a period
        ST_TOUT = 2'd2    // edge lost, waiting for the next one
    } state_t;

    state_t           r_state;
    logic [2:0]       r_sync;      // [0] metastability stage, [1] s2, [2] s3
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_valid;
    logic             r_match;
    logic             r_timeout;

    logic             w_s2;
    logic             w_s3;
    logic             w_rise;
    logic [WIDTH:0]   w_diff;
    logic             w_match;

    assign w_s2   = r_sync[1];
    assign w_s3   = r_sync[2];
    assign w_rise = w_s2 & ~w_s3;

    // Absolute difference, larger minus smaller, so it never underflows.
    always_comb begin
        w_diff = '0;
        if (r_cnt >= i_expect) begin
            w_diff = {1'b0, r_cnt} - {1'b0, i_expect};
        end else begin
            w_diff = {1'b0, i_expect} - {1'b0, r_cnt};
        end
    end

    assign w_match = (w_diff <= {1'b0, TOL});

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync    <= '0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_sync  <= {r_sync[1:0], i_sig};
            r_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_hi  <= '0;
                    if (w_rise) begin
                        // First edge only opens a measurement window.
                        r_state <= ST_MEAS;
                        r_cnt   <= WIDTH'(1);
                        r_hi    <= WIDTH'(1);
                    end
                end

                ST_MEAS: begin
                    if (w_rise) begin
                        // A rise on the same cycle as cnt==MAX_PERIOD still
                        // closes a valid period; the edge wins over timeout.
                        r_period <= r_cnt;
                        r_high   <= r_hi;
                        r_match  <= w_match;
                        r_valid  <= 1'b1;
                        r_cnt    <= WIDTH'(1);
                        r_hi     <= WIDTH'(1);
                    end else if (r_cnt == MAX_PERIOD) begin
                        r_state   <= ST_TOUT;
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_hi      <= '0;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                        r_hi  <= r_hi + WIDTH'(w_s2);
                    end
                end

                ST_TOUT: begin
                    r_cnt <= '0;
                    r_hi  <= '0;
                    if (w_rise) begin
                        // Recovery edge behaves like the first edge: no result.
                        r_state   <= ST_MEAS;
                        r_cnt     <= WIDTH'(1);
                        r_hi      <= WIDTH'(1);
                        r_timeout <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_hi    <= '0;
                end
            endcase
        end
    end

    assign o_period  = r_period;
    assign o_high    = r_high;
    assign o_valid   = r_valid;
    assign o_match   = r_match;
    assign o_timeout = r_timeout;

endmodule
